// File: rtl/jump_pred_pkg.sv
// Shared types and helpers for the jump predictor and its counter table.
package jump_pred_pkg;

  // Decoded jump type presented by the decode stage.
  typedef enum logic [2:0] {
    NONE = 3'd0,
    B    = 3'd1,
    BE   = 3'd2,
    BLT  = 3'd3,
    BLE  = 3'd4,
    BNE  = 3'd5
  } jump_t;

  // Predictor control states: accept at decode, wait one stage, resolve.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } fsm_t;

  // Weak not-taken.
  localparam logic [1:0] CTR_RESET = 2'b01;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/jump_pred_bht.sv
// Branch history table: one 2-bit saturating counter per entry,
// combinational read, synchronous update, synchronous reset to weak not-taken.
module jump_pred_bht
  import jump_pred_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int N = 2 ** IDX_W;

  // All counters flattened so each entry is an independent register.
  logic [2*N-1:0] ctr_flat;

  for (genvar gi = 0; gi < N; gi++) begin : g_ctr
    logic [1:0] ctr_q;

    // Reset to weak not-taken; train only the addressed entry.
    always_ff @(posedge clk) begin
      if (reset) begin
        ctr_q <= CTR_RESET;
      end else if (upd_en && upd_idx == IDX_W'(gi)) begin
        ctr_q <= ctr_next(ctr_q, upd_taken);
      end
    end

    assign ctr_flat[2*gi +: 2] = ctr_q;
  end

  assign rd_ctr = ctr_flat[{rd_idx, 1'b0} +: 2];

endmodule

// File: rtl/jump_pred.sv
// Branch predictor and resolve checker beside the decode stage.
// Predicts conditional jumps from a 2-bit counter table, holds busy until
// the jump resolves two cycles later, flushes and redirects on mispredict.
// Optional statistics counters are enabled by defining JUMP_PRED_STATS_EN.
module jump_pred
  import jump_pred_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memory_waiting,
  input  logic [2:0]      jump_inst,
  input  logic [PC_W-1:0] pc_decode,
  input  logic [PC_W-1:0] target_decode,
  input  logic            jump,
  output logic            jump_pred_busy,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_pc,
  output logic            flush_decode,
  output logic [PC_W-1:0] redirect_pc
`ifdef JUMP_PRED_STATS_EN
  ,
  output logic [15:0]     stat_jumps,
  output logic [15:0]     stat_mispred
`endif
);

  fsm_t             state_q, state_d;
  logic [PC_W-1:0]  cap_pc_q, cap_pc_d;
  logic [PC_W-1:0]  cap_tgt_q, cap_tgt_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic             cap_pred_q, cap_pred_d;

  logic             is_jump;
  logic [1:0]       rd_ctr;
  logic             upd_en;
  logic             mispred;

  // Types 6 and 7 are not jumps.
  assign is_jump = (jump_inst >= 3'd1) && (jump_inst <= 3'd5);

  jump_pred_bht #(.IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_decode[IDX_W-1:0]),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_en),
    .upd_idx   (cap_idx_q),
    .upd_taken (jump)
  );

  // Next-state and outputs; a stall holds every register at its current value.
  always_comb begin
    state_d        = state_q;
    cap_pc_d       = cap_pc_q;
    cap_tgt_d      = cap_tgt_q;
    cap_idx_d      = cap_idx_q;
    cap_pred_d     = cap_pred_q;
    jump_pred_busy = 1'b0;
    pred_taken     = 1'b0;
    flush_decode   = 1'b0;
    redirect_pc    = '0;
    upd_en         = 1'b0;
    mispred        = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_jump) begin
          // Unconditional B is always taken; others follow the counter MSB.
          pred_taken = (jump_inst == B) | rd_ctr[1];
          if (!memory_waiting) begin
            cap_pc_d   = pc_decode;
            cap_tgt_d  = target_decode;
            cap_idx_d  = pc_decode[IDX_W-1:0];
            cap_pred_d = pred_taken;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        jump_pred_busy = 1'b1;
        if (!memory_waiting) state_d = RESOLVE;
      end
      RESOLVE: begin
        jump_pred_busy = 1'b1;
        mispred        = (jump != cap_pred_q);
        // Decode contents are ignored here; if flushed, decode re-presents later.
        if (!memory_waiting) begin
          flush_decode = mispred;
          if (mispred) redirect_pc = jump ? cap_tgt_q : cap_pc_q + PC_W'(1);
          upd_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pred_pc = pred_taken ? target_decode : pc_decode + PC_W'(1);

  // State and captured-jump registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_pc_q   <= '0;
      cap_tgt_q  <= '0;
      cap_idx_q  <= '0;
      cap_pred_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_pc_q   <= cap_pc_d;
      cap_tgt_q  <= cap_tgt_d;
      cap_idx_q  <= cap_idx_d;
      cap_pred_q <= cap_pred_d;
    end
  end

`ifdef JUMP_PRED_STATS_EN
  logic [15:0] stat_jumps_q, stat_mispred_q;

  // Saturating counts of resolved jumps and of mispredicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_jumps_q   <= '0;
      stat_mispred_q <= '0;
    end else if (upd_en) begin
      if (stat_jumps_q != 16'hFFFF) stat_jumps_q <= stat_jumps_q + 16'd1;
      if (mispred && stat_mispred_q != 16'hFFFF) stat_mispred_q <= stat_mispred_q + 16'd1;
    end
  end

  assign stat_jumps   = stat_jumps_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_jump_pred.sv
// Directed testbench for jump_pred with hand-computed expectations.
module tb_jump_pred;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_waiting;
  logic [2:0]  jump_inst;
  logic [15:0] pc_decode;
  logic [15:0] target_decode;
  logic        jump;
  logic        jump_pred_busy;
  logic        pred_taken;
  logic [15:0] pred_pc;
  logic        flush_decode;
  logic [15:0] redirect_pc;
`ifdef JUMP_PRED_STATS_EN
  logic [15:0] stat_jumps;
  logic [15:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;
  int exp_jumps = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  jump_pred dut (
    .clk            (clk),
    .reset          (reset),
    .memory_waiting (memory_waiting),
    .jump_inst      (jump_inst),
    .pc_decode      (pc_decode),
    .target_decode  (target_decode),
    .jump           (jump),
    .jump_pred_busy (jump_pred_busy),
    .pred_taken     (pred_taken),
    .pred_pc        (pred_pc),
    .flush_decode   (flush_decode),
    .redirect_pc    (redirect_pc)
`ifdef JUMP_PRED_STATS_EN
    ,
    .stat_jumps     (stat_jumps),
    .stat_mispred   (stat_mispred)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_stats(input string tag);
`ifdef JUMP_PRED_STATS_EN
    check({tag, "_stat_jumps"}, 32'(stat_jumps), 32'(exp_jumps));
    check({tag, "_stat_mispred"}, 32'(stat_mispred), 32'(exp_mis));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One full jump: decode in IDLE, one WAIT cycle, resolve with 'taken'.
  task automatic do_jump(input string tag, input logic [2:0] jt, input logic [15:0] pc,
                         input logic [15:0] tgt, input logic taken, input logic exp_pred);
    logic        exp_flush;
    logic [15:0] exp_redir;
    logic [15:0] exp_ppc;
    exp_flush = (taken != exp_pred);
    exp_redir = exp_flush ? (taken ? tgt : pc + 16'd1) : 16'd0;
    exp_ppc   = exp_pred ? tgt : pc + 16'd1;
    jump_inst = jt; pc_decode = pc; target_decode = tgt; jump = 1'b0;
    #1;
    check({tag, "_pred"}, 32'(pred_taken), 32'(exp_pred));
    check({tag, "_pred_pc"}, 32'(pred_pc), 32'(exp_ppc));
    check({tag, "_idle_busy"}, 32'(jump_pred_busy), 32'd0);
    step();
    jump_inst = 3'd0;
    #1;
    check({tag, "_wait_busy"}, 32'(jump_pred_busy), 32'd1);
    check({tag, "_wait_flush"}, 32'(flush_decode), 32'd0);
    step();
    jump = taken;
    #1;
    check({tag, "_res_busy"}, 32'(jump_pred_busy), 32'd1);
    check({tag, "_res_flush"}, 32'(flush_decode), 32'(exp_flush));
    check({tag, "_res_redir"}, 32'(redirect_pc), 32'(exp_redir));
    step();
    jump = 1'b0;
    exp_jumps++;
    if (exp_flush) exp_mis++;
    #1;
    check({tag, "_done_busy"}, 32'(jump_pred_busy), 32'd0);
    check_stats(tag);
    $display("jump %s type=%0d pc=%h taken=%0d pred=%0d flush=%0d", tag, jt, pc, taken, exp_pred, exp_flush);
  endtask

  initial begin
    reset = 1'b1; memory_waiting = 1'b0; jump_inst = 3'd0;
    pc_decode = 16'h0000; target_decode = 16'h0000; jump = 1'b0;
    step();
    memory_waiting = 1'b1;  // reset must win over the stall
    step();
    reset = 1'b0; memory_waiting = 1'b0;
    #1;
    check("rst_busy", 32'(jump_pred_busy), 32'd0);
    check("rst_pred", 32'(pred_taken), 32'd0);
    check("rst_flush", 32'(flush_decode), 32'd0);
    check("rst_redir", 32'(redirect_pc), 32'd0);
    check("rst_pred_pc", 32'(pred_pc), 32'h0001);
    check_stats("rst");
    $display("reset released");

    // BE training on idx 0: 01 -> 10 -> 11 -> 11 -> 10 -> 01 -> 00
    do_jump("be1", 3'd2, 16'h0010, 16'h0040, 1'b1, 1'b0);
    do_jump("be2", 3'd2, 16'h0010, 16'h0040, 1'b1, 1'b1);
    do_jump("be3", 3'd2, 16'h0010, 16'h0040, 1'b1, 1'b1);
    do_jump("be4", 3'd2, 16'h0010, 16'h0040, 1'b0, 1'b1);
    do_jump("be5", 3'd2, 16'h0010, 16'h0040, 1'b0, 1'b1);
    do_jump("be6", 3'd2, 16'h0010, 16'h0040, 1'b0, 1'b0);

    // Unconditional B predicts taken even with a not-taken counter.
    do_jump("b", 3'd1, 16'h0005, 16'h0100, 1'b1, 1'b1);

    // BNE with a 3-cycle stall in WAIT and a 1-cycle stall in RESOLVE.
    jump_inst = 3'd5; pc_decode = 16'h0023; target_decode = 16'h0077;
    #1;
    check("stall_pred", 32'(pred_taken), 32'd0);
    check("stall_pred_pc", 32'(pred_pc), 32'h0024);
    step();
    jump_inst = 3'd0; memory_waiting = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_wait_busy", 32'(jump_pred_busy), 32'd1);
      check("stall_wait_flush", 32'(flush_decode), 32'd0);
      step();
    end
    memory_waiting = 1'b0;
    #1;
    check("stall_wait_rel_flush", 32'(flush_decode), 32'd0);
    step();
    memory_waiting = 1'b1; jump = 1'b1;
    #1;
    check("stall_res_flush", 32'(flush_decode), 32'd0);
    check("stall_res_busy", 32'(jump_pred_busy), 32'd1);
    step();
    memory_waiting = 1'b0;
    #1;
    check("stall_rel_flush", 32'(flush_decode), 32'd1);
    check("stall_rel_redir", 32'(redirect_pc), 32'h0077);
    step();
    jump = 1'b0;
    exp_jumps++; exp_mis++;
    #1;
    check("stall_done_busy", 32'(jump_pred_busy), 32'd0);
    check_stats("stall");
    $display("jump stall type=5 pc=0023 taken=1 pred=0 flush=1");

    // idx 3 should now hold 10: one train under stall, not more.
    do_jump("bne_a", 3'd5, 16'h0013, 16'h0070, 1'b0, 1'b1);
    do_jump("bne_b", 3'd5, 16'h0033, 16'h0070, 1'b0, 1'b0);

    // Jump presented during a mispredicting RESOLVE is not captured.
    jump_inst = 3'd2; pc_decode = 16'h0030; target_decode = 16'h0050;
    #1;
    check("ovl_pred", 32'(pred_taken), 32'd0);
    step();
    jump_inst = 3'd0;
    step();
    jump_inst = 3'd3; pc_decode = 16'h0007; target_decode = 16'h0099; jump = 1'b1;
    #1;
    check("ovl_res_pred", 32'(pred_taken), 32'd0);
    check("ovl_res_flush", 32'(flush_decode), 32'd1);
    check("ovl_res_redir", 32'(redirect_pc), 32'h0050);
    step();
    jump = 1'b0;
    exp_jumps++; exp_mis++;
    #1;
    check("ovl_idle_busy", 32'(jump_pred_busy), 32'd0);
    check("ovl_idle_pred", 32'(pred_taken), 32'd0);
    check_stats("ovl");
    $display("jump ovl type=2 pc=0030 taken=1 pred=0 flush=1");
    do_jump("blt_re", 3'd3, 16'h0007, 16'h0099, 1'b1, 1'b0);

    // Reset while in WAIT: back to IDLE, no flush, table cleared.
    jump_inst = 3'd4; pc_decode = 16'h0017; target_decode = 16'h0088;
    #1;
    check("rw_pred", 32'(pred_taken), 32'd1);
    step();
    jump_inst = 3'd0; reset = 1'b1;
    step();
    reset = 1'b0;
    exp_jumps = 0; exp_mis = 0;
    #1;
    check("rw_busy", 32'(jump_pred_busy), 32'd0);
    check("rw_flush", 32'(flush_decode), 32'd0);
    check("rw_redir", 32'(redirect_pc), 32'd0);
    check_stats("rw");
    step();
    check("rw_busy2", 32'(jump_pred_busy), 32'd0);
    check("rw_flush2", 32'(flush_decode), 32'd0);
    $display("reset in WAIT done");
    do_jump("ble_clr", 3'd4, 16'h0017, 16'h0088, 1'b0, 1'b0);
    do_jump("wrap", 3'd2, 16'hFFFF, 16'h1234, 1'b0, 1'b0);

    // Types 6/7 are not jumps.
    jump_inst = 3'd6; pc_decode = 16'h0010; target_decode = 16'h0040;
    #1;
    check("t6_pred", 32'(pred_taken), 32'd0);
    step();
    check("t6_busy", 32'(jump_pred_busy), 32'd0);
    jump_inst = 3'd7;
    #1;
    check("t7_pred", 32'(pred_taken), 32'd0);
    step();
    check("t7_busy", 32'(jump_pred_busy), 32'd0);
    $display("non-jump types 6/7 ignored");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
